lsu: RTL

Load/store unit forming the memory-access stage of the core: accepts one load or store per request from execute, drives the byte-addressed big-endian data RAM, and returns load results to write-back. The RAM only supports full 32-bit word writes, so the unit performs read-modify-write for byte and halfword stores. It also performs load byte/halfword extraction with sign or zero extension and flags misaligned accesses.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_if.sv | 43 ++++
 rtl/lsu_align.sv | 64 ++++++
 rtl/lsu.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: width codes, FSM states
// and the funct3 -> access width decode used by the top and the align datapath.
package lsu_pkg;

    localparam int DATA_W       = 32;
    localparam int ADDR_W_DFLT  = 32;

    localparam logic ENABLED  = 1'b1;
    localparam logic DISABLED = 1'b0;
    localparam logic [DATA_W-1:0] ZERO = '0;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        WIDTH_B = 2'd0,
        WIDTH_H = 2'd1,
        WIDTH_W = 2'd2
    } width_e;

    // Any code outside the byte/halfword set falls back to a full word access.
    function automatic width_e decode_width(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return WIDTH_B;
            F3_H, F3_HU: return WIDTH_H;
            default:     return WIDTH_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, data-RAM and write-back signals of the load/store unit.
// The lsu uses the slave modport; the surrounding core/testbench uses master.
interface lsu_if #(parameter int ADDR_W = 32);

    logic              in_valid;
    logic              in_ready;
    logic              in_load;
    logic              in_store;
    logic [2:0]        in_funct3;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_wdata;
    logic [4:0]        in_rd;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_waddr;
    logic [ADDR_W-1:0] ram_raddr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic              out_valid;
    logic              out_wen;
    logic [4:0]        out_rd;
    logic [31:0]       out_data;
    logic              out_misalign;

    modport master (
        output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
        input  in_ready,
        input  ram_we, ram_re, ram_waddr, ram_raddr, ram_wdata,
        output ram_rdata,
        input  out_valid, out_wen, out_rd, out_data, out_misalign
    );

    modport slave (
        input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
        output in_ready,
        output ram_we, ram_re, ram_waddr, ram_raddr, ram_wdata,
        input  ram_rdata,
        output out_valid, out_wen, out_rd, out_data, out_misalign
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational datapath: big-endian load extract/extend, sub-word store merge
// into the old RAM word, and the alignment check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] ram_rdata,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic [31:0] merged_word,
    output logic        misalign
);

    width_e      width;
    logic        sign_ext;
    logic [31:0] shifted;
    logic [3:0]  lane_mask;

    assign width    = decode_width(funct3);
    assign sign_ext = ~funct3[2];

    // The addressed byte is the MSB of the RAM word, so sub-word data sits at the top.
    always_comb begin
        case (width)
            WIDTH_B: load_value = {{24{sign_ext & ram_rdata[31]}}, ram_rdata[31:24]};
            WIDTH_H: load_value = {{16{sign_ext & ram_rdata[31]}}, ram_rdata[31:16]};
            default: load_value = ram_rdata;
        endcase
    end

    always_comb begin
        shifted   = wdata;
        lane_mask = 4'b1111;
        case (width)
            WIDTH_B: begin
                shifted   = {wdata[7:0], 24'h0};
                lane_mask = 4'b1000;
            end
            WIDTH_H: begin
                shifted   = {wdata[15:0], 16'h0};
                lane_mask = 4'b1100;
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[gi*8 +: 8] = lane_mask[gi] ? shifted[gi*8 +: 8]
                                                          : old_word[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        case (width)
            WIDTH_H: misalign = addr_lo[0];
            WIDTH_W: misalign = |addr_lo;
            default: misalign = 1'b0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit top: request latch, IDLE/ACCESS/MERGE FSM, read-modify-write
// merge register and registered write-back outputs.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT
)(
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    lsu_state_e        state_reg;
    logic              load_reg;
    logic              store_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [4:0]        rd_reg;
    logic [31:0]       merge_reg;

    logic              out_valid_reg;
    logic              out_wen_reg;
    logic [4:0]        out_rd_reg;
    logic [31:0]       out_data_reg;
    logic              out_misalign_reg;

    logic              is_load;
    logic              is_store;
    logic              sub_store;
    logic              misalign_raw;
    logic              suppress;
    logic [31:0]       load_value;
    logic [31:0]       merged_word;

    logic              ram_we_drv;
    logic              ram_re_drv;
    logic [ADDR_W-1:0] ram_waddr_drv;
    logic [ADDR_W-1:0] ram_raddr_drv;
    logic [31:0]       ram_wdata_drv;

    // A request with both flags set is a load.
    assign is_load   = load_reg;
    assign is_store  = store_reg & ~load_reg;
    assign sub_store = is_store & (decode_width(funct3_reg) != WIDTH_W);
    assign suppress  = misalign_raw & (is_load | is_store);

    lsu_align u_align (
        .funct3      (funct3_reg),
        .addr_lo     (addr_reg[1:0]),
        .ram_rdata   (bus.ram_rdata),
        .old_word    (merge_reg),
        .wdata       (wdata_reg),
        .load_value  (load_value),
        .merged_word (merged_word),
        .misalign    (misalign_raw)
    );

    // Enables decode straight from state so an asynchronous reset kills a pending write.
    always_comb begin
        ram_we_drv    = DISABLED;
        ram_re_drv    = DISABLED;
        ram_waddr_drv = '0;
        ram_raddr_drv = '0;
        ram_wdata_drv = ZERO;
        case (state_reg)
            ST_ACCESS: begin
                if (!suppress && (is_load || sub_store)) begin
                    ram_re_drv    = ENABLED;
                    ram_raddr_drv = addr_reg;
                end else if (!suppress && is_store) begin
                    ram_we_drv    = ENABLED;
                    ram_waddr_drv = addr_reg;
                    ram_wdata_drv = wdata_reg;
                end
            end
            ST_MERGE: begin
                ram_we_drv    = ENABLED;
                ram_waddr_drv = addr_reg;
                ram_wdata_drv = merged_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            load_reg         <= 1'b0;
            store_reg        <= 1'b0;
            funct3_reg       <= '0;
            addr_reg         <= '0;
            wdata_reg        <= ZERO;
            rd_reg           <= '0;
            merge_reg        <= ZERO;
            out_valid_reg    <= 1'b0;
            out_wen_reg      <= 1'b0;
            out_rd_reg       <= '0;
            out_data_reg     <= ZERO;
            out_misalign_reg <= 1'b0;
        end else begin
            out_valid_reg    <= 1'b0;
            out_wen_reg      <= 1'b0;
            out_misalign_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        load_reg   <= bus.in_load;
                        store_reg  <= bus.in_store;
                        funct3_reg <= bus.in_funct3;
                        addr_reg   <= bus.in_addr;
                        wdata_reg  <= bus.in_wdata;
                        rd_reg     <= bus.in_rd;
                        state_reg  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (sub_store && !suppress) begin
                        merge_reg <= bus.ram_rdata;
                        state_reg <= ST_MERGE;
                    end else begin
                        out_valid_reg    <= 1'b1;
                        out_wen_reg      <= is_load & ~suppress & (rd_reg != 5'd0);
                        out_misalign_reg <= suppress;
                        out_rd_reg       <= rd_reg;
                        if (is_load && !suppress) begin
                            out_data_reg <= load_value;
                        end
                        state_reg <= ST_IDLE;
                    end
                end
                ST_MERGE: begin
                    out_valid_reg <= 1'b1;
                    out_rd_reg    <= rd_reg;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (state_reg == ST_IDLE);
    assign bus.ram_we       = ram_we_drv;
    assign bus.ram_re       = ram_re_drv;
    assign bus.ram_waddr    = ram_waddr_drv;
    assign bus.ram_raddr    = ram_raddr_drv;
    assign bus.ram_wdata    = ram_wdata_drv;
    assign bus.out_valid    = out_valid_reg;
    assign bus.out_wen      = out_wen_reg;
    assign bus.out_rd       = out_rd_reg;
    assign bus.out_data     = out_data_reg;
    assign bus.out_misalign = out_misalign_reg;

endmodule
